fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that owns the program counter and sequences the PC incrementer (PC + 4) against a single-port instruction memory with a req/ack handshake. It sits at the front of the CPU datapath and takes redirects from decode (jump) and execute (branch). It delivers one instruction at a time to the decode stage with a valid/stall handshake.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential increment added to PC
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- stall  in  1  decode cannot accept the presented instruction this cycle
- branch_taken  in  1  execute-stage redirect strobe
- branch_target  in  32  branch destination, valid with branch_taken
- jump  in  1  decode-stage redirect strobe
- jump_target  in  32  jump destination, valid with jump
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address
- imem_ack  in  1  memory has returned data on imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- instr_valid  out  1  instr/instr_pc hold a deliverable instruction
- instr  out  32  delivered instruction
- instr_pc  out  32  address of delivered instruction
- pc  out  32  current fetch PC

## Operation
- Three states: IDLE, FETCH, DELIVER. All outputs are registered.
- Redirect target: branch_target if branch_taken, else jump_target if jump. Branch wins when both are asserted, because it comes from the older instruction.
- IDLE: entered on reset. Moves to FETCH unconditionally on the first clock edge after reset deasserts. imem_ack is ignored in IDLE.
- FETCH:
  - imem_req=1 and imem_addr=pc.
  - Without ack, a redirect loads redir_pend=1 and redir_pc=target, and pc/imem_addr stay unchanged.
  - On ack with no redirect this cycle and no pending redirect: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP, next state DELIVER.
  - On ack with a redirect this cycle or a pending redirect: discard imem_rdata and keep instr_valid=0. pc takes this cycle's redirect target if present, otherwise redir_pc. Clear redir_pend and stay in FETCH, which presents the new address next cycle.
- DELIVER:
  - imem_req=0 and instr_valid=1.
  - Redirect: squash the held instruction (instr_valid<=0), pc<=target, go to FETCH. Redirect takes priority over stall.
  - Otherwise stall=1: hold instr, instr_pc, pc and state.
  - Otherwise stall=0: the instruction is consumed this cycle; instr_valid<=0 and go to FETCH.
  - imem_ack is ignored in DELIVER.
- Arithmetic: pc+PC_STEP is 32-bit modulo 2^32, so 32'hFFFF_FFFC+4 = 0. Targets are used as given, with no alignment masking.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, pc=RESET_PC, imem_addr=RESET_PC
  - imem_req=0, instr_valid=0, instr=0, instr_pc=0, redir_pend=0
- A reset asserted mid-FETCH drops imem_req immediately. A late ack arriving afterwards is ignored.
- Handshake: while imem_req=1 and imem_ack=0, imem_addr and imem_req stay stable. An ack may arrive in the same cycle as the request is raised (zero-wait memory).
- Latency:
  - First imem_req is high in the 2nd cycle after reset deasserts.
  - With zero-wait memory and no stall, instr_valid is high every other cycle, giving a peak throughput of 1 instruction per 2 cycles.
  - instr_valid rises on the clock edge that samples imem_ack.
  - A redirect in DELIVER produces imem_addr=target in the following cycle.
- Only one redirect can be pending; a later redirect overwrites redir_pc (newest wins).

## Test plan
- Reset, RESET_PC=0, imem_ack tied 1, stall=0, imem_rdata=addr^32'hA5A5_0000:
  - instr_pc sequence is 0,4,8,12, with instr_valid high on alternate cycles.
  - Each instr matches its address-derived data.
- Hold stall=1 for 3 cycles while instr_pc=0x8:
  - instr, instr_pc=0x8 and pc=0xC are held; imem_req stays 0.
  - Fetch of 0xC starts the cycle after stall drops.
- branch_taken=1, branch_target=0x100 during DELIVER with stall=1:
  - instr_valid=0 next cycle, then imem_addr=0x100 with imem_req=1.
- jump=1, jump_target=0x200 while FETCH of 0x10 waits (ack delayed 3 cycles):
  - imem_addr stays 0x10 until ack.
  - The data is discarded and instr_valid stays 0.
  - The next request is to 0x200.
- branch_taken (0x40) and jump (0x80) in the same DELIVER cycle: next fetch is 0x40.
- Wrap and reset:
  - RESET_PC=32'hFFFF_FFFC: the first delivered instr_pc is 0xFFFF_FFFC and the next fetch address is 0.
  - Asserting reset mid-FETCH gives all outputs their reset values within the same cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and sequences single-port instruction fetches into a
// one-deep delivery slot, with branch/jump redirects that squash in-flight or held work.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc
);
    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, instr_n, instr_pc_n, redir_pc, redir_pc_n, target;
    logic        redir_pend, redir_pend_n, redirect;

    // Branch wins over jump because it belongs to the older instruction.
    assign redirect = branch_taken | jump;
    assign target   = branch_taken ? branch_target : jump_target;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        instr_n      = instr;
        instr_pc_n   = instr_pc;
        redir_pend_n = redir_pend;
        redir_pc_n   = redir_pc;
        case (state)
            IDLE: state_n = FETCH;
            FETCH: begin
                if (imem_ack && (redirect || redir_pend)) begin
                    pc_n         = redirect ? target : redir_pc;
                    redir_pend_n = 1'b0;
                end else if (imem_ack) begin
                    instr_n    = imem_rdata;
                    instr_pc_n = pc;
                    pc_n       = pc + PC_STEP;
                    state_n    = DELIVER;
                end else if (redirect) begin
                    redir_pend_n = 1'b1;
                    redir_pc_n   = target;
                end
            end
            DELIVER: begin
                if (redirect) begin
                    pc_n    = target;
                    state_n = FETCH;
                end else if (!stall) begin
                    state_n = FETCH;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_addr   <= RESET_PC;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            redir_pend  <= 1'b0;
            redir_pc    <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            imem_addr   <= pc_n;
            imem_req    <= state_n == FETCH;
            instr_valid <= state_n == DELIVER;
            instr       <= instr_n;
            instr_pc    <= instr_pc_n;
            redir_pend  <= redir_pend_n;
            redir_pc    <= redir_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed walk through the fetch/stall/redirect cases, then randomized
// traffic checked by a scoreboard predicting the architectural stream of delivered PCs.
module tb_fetch_sequencer;
    localparam logic [31:0] KEY     = 32'hA5A5_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, imem_ack = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_rdata, w_instr, w_instr_pc, w_pc;

    int          checks = 0, errors = 0, deliveries = 0;
    logic [31:0] exp_q[$];
    logic [31:0] e, hs_addr = '0;
    logic        prev_valid = 1'b0, hs_pend = 1'b0, ok;

    always #5 clk = ~clk;

    // Memory returns a word derived from its address so each delivery is self-identifying.
    assign imem_rdata = imem_addr ^ KEY;
    assign w_rdata    = w_addr ^ KEY;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .pc(pc)
    );

    fetch_sequencer #(.RESET_PC(WRAP_PC)) u_wrap (
        .clk(clk), .reset(reset), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .jump(1'b0), .jump_target(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_ack(1'b1), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr(w_instr), .instr_pc(w_instr_pc), .pc(w_pc)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"}, pc, 32'h0);
        chk({tag, "_addr"}, imem_addr, 32'h0);
        chk({tag, "_req"}, imem_req, 32'h0);
        chk({tag, "_valid"}, instr_valid, 32'h0);
        chk({tag, "_instr"}, instr, 32'h0);
        chk({tag, "_instr_pc"}, instr_pc, 32'h0);
    endtask

    // Reference model: the next PC the decode stage should see. A redirect replaces it;
    // a delivery advances it by one word. Also records the fetch handshake at each edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
            hs_pend = 1'b0;
        end else begin
            hs_pend = imem_req && !imem_ack;
            hs_addr = imem_addr;
            if (branch_taken || jump) begin
                exp_q.delete();
                exp_q.push_back(branch_taken ? branch_target : jump_target);
            end
        end
    end

    // Monitor: every fresh delivery pops the scoreboard; a waiting request must stay stable.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_valid && !prev_valid) begin
                deliveries++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got delivery of %h want none", instr_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr_pc", instr_pc, e);
                    chk("sb_instr", instr, e ^ KEY);
                    if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
                end
            end
            if (hs_pend) begin
                chk("hs_req", imem_req, 32'h1);
                chk("hs_addr", imem_addr, hs_addr);
            end
        end
        prev_valid = instr_valid;
    end

    initial begin
        repeat (2) @(negedge clk);
        chk_reset("rst");
        chk("rst_wrap_pc", w_pc, WRAP_PC);
        chk("rst_wrap_addr", w_addr, WRAP_PC);
        imem_ack = 1'b1;
        reset    = 1'b0;
        @(negedge clk);
        chk("first_req", imem_req, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("idle_ack_ignored", instr_valid, 32'h0);
        @(negedge clk);
        chk("seq0_valid", instr_valid, 32'h1);
        chk("seq0_pc", instr_pc, 32'h0);
        chk("wrap_instr_pc", w_instr_pc, WRAP_PC);
        chk("wrap_instr", w_instr, WRAP_PC ^ KEY);
        @(negedge clk);
        chk("seq_gap_valid", instr_valid, 32'h0);
        chk("wrap_next_addr", w_addr, 32'h0);
        chk("wrap_next_req", w_req, 32'h1);
        @(negedge clk);
        chk("seq4_pc", instr_pc, 32'h4);
        @(negedge clk);
        chk("seq_gap2_valid", instr_valid, 32'h0);
        @(negedge clk);
        chk("seq8_pc", instr_pc, 32'h8);
        stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_instr_pc", instr_pc, 32'h8);
            chk("stall_instr", instr, 32'h8 ^ KEY);
            chk("stall_pc", pc, 32'hC);
            chk("stall_req", imem_req, 32'h0);
            chk("stall_valid", instr_valid, 32'h1);
        end
        stall = 1'b0;
        @(negedge clk);
        chk("post_stall_req", imem_req, 32'h1);
        chk("post_stall_addr", imem_addr, 32'hC);
        @(negedge clk);
        chk("seqC_pc", instr_pc, 32'hC);
        imem_ack = 1'b0;
        @(negedge clk);
        chk("wait_addr0", imem_addr, 32'h10);
        jump        = 1'b1;
        jump_target = 32'h200;
        repeat (3) begin
            @(negedge clk);
            jump = 1'b0;
            chk("wait_addr", imem_addr, 32'h10);
            chk("wait_valid", instr_valid, 32'h0);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        chk("discard_valid", instr_valid, 32'h0);
        chk("pend_addr", imem_addr, 32'h200);
        chk("pend_req", imem_req, 32'h1);
        @(negedge clk);
        chk("jump_dest_pc", instr_pc, 32'h200);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        jump          = 1'b1;
        jump_target   = 32'h80;
        @(negedge clk);
        branch_taken = 1'b0;
        jump         = 1'b0;
        chk("prio_addr", imem_addr, 32'h40);
        chk("prio_valid", instr_valid, 32'h0);
        @(negedge clk);
        chk("prio_pc", instr_pc, 32'h40);
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        @(negedge clk);
        stall        = 1'b0;
        branch_taken = 1'b0;
        chk("squash_valid", instr_valid, 32'h0);
        chk("squash_addr", imem_addr, 32'h100);
        chk("squash_req", imem_req, 32'h1);
        imem_ack = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        imem_ack = 1'b1;
        #1 chk_reset("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("late_ack_valid", instr_valid, 32'h0);
        chk("restart_addr", imem_addr, 32'h0);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            stall         = $urandom_range(3) == 0;
            imem_ack      = imem_req ? ($urandom_range(2) != 0) : ($urandom_range(5) == 0);
            ok            = imem_req || instr_valid;
            branch_taken  = ok && ($urandom_range(11) == 0);
            jump          = ok && ($urandom_range(11) == 0);
            branch_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            jump_target   = $urandom();
        end
        @(negedge clk);
        branch_taken = 1'b0;
        jump         = 1'b0;
        chk("deliveries_seen", 32'(deliveries > 300), 32'h1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
